// File: rtl/alu_operand_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_regfile
// Purpose  : Eight-entry operand register file with carry flag feeding a
//            16-bit ALU. A/B/Cin are registered; ALU results (F, Cout) are
//            written back on command with same-edge write forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_regfile #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int ZERO_R0 = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    AA,
   input  logic [AW-1:0]    BA,
   input  logic [AW-1:0]    DA,
   input  logic             RW,
   input  logic [WIDTH-1:0] D,
   input  logic             CW,
   input  logic             Cout_in,
   input  logic             CLRC,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             Cin,
   output logic             Aval
);

   localparam logic C_ZERO_R0 = (ZERO_R0 != 0);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             cin_q, cin_d;
   logic             aval_q;

   logic             w_da_in_range;
   logic             w_wr_en;

   // Qualify the write: destination must exist and must not be a hard-wired R0
   always_comb begin
      w_da_in_range = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (DA == AW'(i)) w_da_in_range = 1'b1;
      end
      w_wr_en = RW && w_da_in_range && !(C_ZERO_R0 && (DA == '0));
   end

   // Operand selection with forwarding of a write landing on the same edge
   always_comb begin
      a_d = '0;
      b_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (AA == AW'(i)) a_d = regs_q[i];
         if (BA == AW'(i)) b_d = regs_q[i];
      end
      if (w_wr_en && (DA == AA)) a_d = D;
      if (w_wr_en && (DA == BA)) b_d = D;
      if (C_ZERO_R0 && (AA == '0)) a_d = '0;
      if (C_ZERO_R0 && (BA == '0)) b_d = '0;
   end

   // Carry flag next state: clear wins over capture, otherwise hold
   always_comb begin
      cin_d = cin_q;
      if (CLRC)    cin_d = 1'b0;
      else if (CW) cin_d = Cout_in;
   end

   // Register array write-back
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_en && (DA == AW'(i))) regs_q[i] <= D;
         end
      end
   end

   // Operand, carry and valid output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         cin_q  <= 1'b0;
         aval_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         cin_q  <= cin_d;
         aval_q <= 1'b1;
      end
   end

   assign A    = a_q;
   assign B    = b_q;
   assign Cin  = cin_q;
   assign Aval = aval_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_regfile
// Purpose  : Directed self-checking bench for alu_operand_regfile with a
//            reference model and an expected-output queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_regfile;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        aval;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  AA = '0, BA = '0, DA = '0;
   logic        RW = 1'b0, CW = 1'b0, Cout_in = 1'b0, CLRC = 1'b0;
   logic [15:0] D = '0;
   logic [15:0] A, B;
   logic        Cin, Aval;

   int total = 0;
   int bad   = 0;

   exp_t        sb [$];
   logic [15:0] m_reg [8];
   logic        m_cin  = 1'b0;
   logic        m_aval = 1'b0;

   alu_operand_regfile #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_R0(1)) dut (
      .clk(clk), .rst(rst), .AA(AA), .BA(BA), .DA(DA), .RW(RW), .D(D),
      .CW(CW), .Cout_in(Cout_in), .CLRC(CLRC),
      .A(A), .B(B), .Cin(Cin), .Aval(Aval)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] mval(input logic [2:0] x, input logic rw,
                                        input logic [2:0] da, input logic [15:0] d);
      if (x == 3'd0) return 16'h0000;
      if (rw && da == x) return d;
      return m_reg[x];
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock step: drive, push expectation, clock, pop and compare
   task automatic step(input string tag, input logic [2:0] aa, input logic [2:0] ba,
                       input logic [2:0] da, input logic rw, input logic [15:0] d,
                       input logic cw, input logic co, input logic clrc);
      exp_t e, got;
      AA = aa; BA = ba; DA = da; RW = rw; D = d; CW = cw; Cout_in = co; CLRC = clrc;
      e.a    = mval(aa, rw, da, d);
      e.b    = mval(ba, rw, da, d);
      e.cin  = clrc ? 1'b0 : (cw ? co : m_cin);
      e.aval = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      if (rw && da != 3'd0) m_reg[da] = d;
      m_cin  = e.cin;
      m_aval = 1'b1;
      #1;
      if (sb.size() == 0) begin
         total++; bad++;
         $error("FAIL %s_queue observed=empty expected=entry", tag);
      end else begin
         got = sb.pop_front();
         chk({tag, "_A"},    A,            got.a);
         chk({tag, "_B"},    B,            got.b);
         chk({tag, "_Cin"},  {15'd0, Cin}, {15'd0, got.cin});
         chk({tag, "_Aval"}, {15'd0, Aval},{15'd0, got.aval});
      end
      RW = 1'b0; CW = 1'b0; CLRC = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;

      // Reset state while rst held through an edge
      #7;
      chk("rst_A", A, 16'h0000);
      chk("rst_B", B, 16'h0000);
      chk("rst_Cin", {15'd0, Cin}, 16'h0000);
      chk("rst_Aval", {15'd0, Aval}, 16'h0000);
      #1 rst = 1'b0;
      @(posedge clk); #1;   // first edge after release: outputs leave reset
      m_aval = 1'b1;

      // Write reg3, read it back, set carry
      step("w3",   3'd0, 3'd0, 3'd3, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
      step("r3",   3'd3, 3'd3, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("r3_direct", A, 16'h1234);

      // Asynchronous reset mid-cycle, no clock edge
      #2 rst = 1'b1;
      #1;
      chk("async_A", A, 16'h0000);
      chk("async_B", B, 16'h0000);
      chk("async_Cin", {15'd0, Cin}, 16'h0000);
      chk("async_Aval", {15'd0, Aval}, 16'h0000);
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
      m_cin = 1'b0; m_aval = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      step("post_rst", 3'd3, 3'd3, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("post_rst_direct", A, 16'h0000);

      // Write then read with prior-cycle read visible first
      step("w5", 3'd1, 3'd1, 3'd5, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
      chk("w5_prior", A, 16'h0000);
      step("r5", 3'd5, 3'd5, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("r5_A", A, 16'hBEEF);
      chk("r5_B", B, 16'hBEEF);

      // Forwarding: write reg2 while reading it, reg4 preloaded
      step("w4",  3'd0, 3'd0, 3'd4, 1'b1, 16'h0F0F, 1'b0, 1'b0, 1'b0);
      step("fwd", 3'd2, 3'd4, 3'd2, 1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
      chk("fwd_A", A, 16'hA5A5);
      chk("fwd_B", B, 16'h0F0F);
      step("r2",  3'd4, 3'd2, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("r2_B", B, 16'hA5A5);

      // R0 hard-wired zero
      step("r0w", 3'd0, 3'd0, 3'd0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      chk("r0w_A", A, 16'h0000);
      step("r0r", 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("r0r_A", A, 16'h0000);

      // Carry flag: capture, hold, clear priority; simultaneous reg write
      step("c_set",  3'd0, 3'd0, 3'd6, 1'b1, 16'h5555, 1'b1, 1'b1, 1'b0);
      chk("c_set_direct", {15'd0, Cin}, 16'h0001);
      step("c_hold0", 3'd6, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      step("c_hold1", 3'd6, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      step("c_hold2", 3'd6, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("c_hold_direct", {15'd0, Cin}, 16'h0001);
      chk("w6_direct", A, 16'h5555);
      step("c_clr", 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
      chk("c_clr_direct", {15'd0, Cin}, 16'h0000);

      // Closed loop with an A+B ALU: reg1 counts up by one per cycle
      step("l_w1", 3'd0, 3'd0, 3'd1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
      step("l_w2", 3'd0, 3'd0, 3'd2, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
      step("l_rd", 3'd1, 3'd2, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("l_rd_A", A, 16'h0000);
      for (int k = 1; k <= 6; k++) begin
         step("loop", 3'd1, 3'd2, 3'd1, 1'b1, A + B, 1'b0, 1'b0, 1'b0);
         chk("loop_count", A, 16'(k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_operand_regfile.md
Name: alu_operand_regfile

Overview:
- Operand register file that sits directly upstream of the 16-bit ALU (ports Cin, A, B, FS, Cout, F).
- Holds eight 16-bit general registers and a carry flag.
- Presents registered A/B operands and Cin to the ALU.
- Writes ALU results F and carry-out Cout back on command, closing the datapath loop without any combinational path from F to A/B.

Parameters:
- WIDTH, 16, data width of registers and operand ports.
- DEPTH, 8, number of general registers.
- AW, 3, address width (log2 DEPTH).
- ZERO_R0, 1, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- AA  input  AW  read address for operand A.
- BA  input  AW  read address for operand B.
- DA  input  AW  write destination address.
- RW  input  1  register write enable.
- D  input  WIDTH  write data (ALU F).
- CW  input  1  carry flag write enable.
- Cout_in  input  1  carry value to capture (ALU Cout).
- CLRC  input  1  synchronous carry flag clear.
- A  output  WIDTH  registered operand A to ALU.
- B  output  WIDTH  registered operand B to ALU.
- Cin  output  1  carry flag to ALU Cin.
- Aval  output  1  high when A/B/Cin hold operands for the address pair sampled the previous cycle.

Behaviour:
- Reset: asynchronous on rst high.
  - All registers, A, B, Cin and Aval go to 0 immediately.
  - A reset asserted mid-operation discards any pending write that edge.
  - Outputs leave reset on the first rising clk after rst deasserts.
- Write: at a rising edge with RW=1, reg[DA] <= D.
  - When ZERO_R0=1 and DA=0, the write is dropped.
- Read latency is one cycle.
  - At each rising edge, A <= value(AA) and B <= value(BA).
  - value(x) is reg[x], except when RW=1 and DA=x and the write is not dropped: value(x) is then D (write-forwarding at the same edge).
  - value(0)=0 when ZERO_R0=1.
- AA=BA is legal; both outputs carry the same value.
- A, B and Cin are pure flop outputs. There is no combinational path from any input to any output.
- Carry flag update, applied at the rising edge in priority order:
  - CLRC=1: Cin <= 0.
  - Otherwise CW=1: Cin <= Cout_in.
  - Otherwise Cin holds.
  - The new carry is visible on Cin in the cycle after the edge.
- Aval <= 1 at the first edge after reset and stays 1. Aval=0 in the reset cycle.
- Simultaneous register write and carry write are independent and both take effect at the same edge.
- Addresses at or above DEPTH cannot occur when DEPTH=2^AW. For other DEPTH values, out-of-range writes are dropped and out-of-range reads return 0.
- No X propagation from uninitialised storage: every register has a defined reset value.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writing reg3=16'h1234 -> A, B and Cin go to 0 immediately without a clock edge. Reading AA=3 after release returns 16'h0000.
- Write then read:
  - Write DA=5, D=16'hBEEF, RW=1 at edge n.
  - Set AA=5, BA=5 at edge n+1 -> A=B=16'hBEEF after edge n+1.
  - Before edge n+1, A shows the prior-cycle read.
- Forwarding: at one edge RW=1, DA=2, D=16'hA5A5 and AA=2, BA=4 (reg4=16'h0F0F) -> after the edge A=16'hA5A5, B=16'h0F0F, and reg2 reads 16'hA5A5 on later cycles.
- R0 with ZERO_R0=1: write DA=0, D=16'hFFFF with RW=1 and AA=0 at the same edge -> A=16'h0000 then and thereafter.
- Carry flag:
  - CW=1, Cout_in=1 -> Cin=1 next cycle.
  - CW=0 with Cout_in toggling -> Cin holds 1.
  - CLRC=1 and CW=1, Cout_in=1 at the same edge -> Cin=0.
- Closed loop with ALU: chain DA=AA=1 and BA=2 (reg2=16'h0001) with RW=1 each cycle, D driven by the ALU's A+B output -> reg1 increments by 1 every cycle (0,1,2,3…). No combinational loop is reported by the simulator or lint.
